// File: rtl/io_bridge_pkg.sv
// Shared constants, FIFO entry type and FSM state types for the CPU-side I/O bridge.
// Display pacing is compiled in only when IO_SEG_PACE_EN is defined.
package io_bridge_pkg;

  localparam logic [23:0] IO_BASE    = 24'hFFFFFF;
  localparam logic [7:0]  IO_SEG     = 8'h0C;
  localparam logic [7:0]  IO_SEG_RDY = 8'h08;
  localparam logic [7:0]  IO_SWX     = 8'h14;
  localparam logic [7:0]  IO_BTN     = 8'h20;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wbufEntry_t;

  typedef enum logic {D_IDLE, D_SEGWR} drainState_t;
  typedef enum logic {L_IDLE, L_RESP}  loadState_t;

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-port and PDU I/O-bus signals seen by the bridge (master) and its environment (slave).
interface io_bridge_if;

  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, dm_rdata, io_din,
    output cpu_rdata, cpu_stall, dm_we, io_addr, io_dout, io_we, io_rd
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, dm_rdata, io_din,
    input  cpu_rdata, cpu_stall, dm_we, io_addr, io_dout, io_we, io_rd
  );

endinterface

// File: rtl/io_bridge_wbuf.sv
// Posted-write FIFO for I/O stores: push/pop with full/empty flags and a combinational head entry.
module io_wbuf
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  wbufEntry_t pushData_i,
  input  logic       pop_i,
  output wbufEntry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = $clog2(DEPTH);

  wbufEntry_t    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [PW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_bridge.sv
// CPU-side memory-mapped I/O bridge: posted I/O writes via a FIFO, single-pulse I/O reads.
// Define IO_SEG_PACE_EN to pace display-port (0x0C) writes on the PDU display-ready flag.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  io_bridge_if.master bus
);

  logic        ioHit;
  logic        ioStore;
  logic        ioLoad;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  wbufEntry_t  head;
  wbufEntry_t  pushEntry;

  drainState_t drainState_q, drainState_d;
  loadState_t  loadState_q, loadState_d;
  logic [31:0] rdata_q, rdata_d;

  logic        drainWe;
  logic [7:0]  drainAddr;
  logic [31:0] drainDout;
  logic        loadRd;
  logic [7:0]  loadAddr;
  logic        loadStall;

  assign ioHit     = (bus.cpu_addr[31:8] == IO_BASE);
  assign ioStore   = bus.cpu_we & ioHit;
  assign ioLoad    = bus.cpu_re & ioHit;
  assign push      = ioStore & ~full;
  assign pushEntry = '{addr: bus.cpu_addr[7:0], data: bus.cpu_wdata};

  io_wbuf #(.DEPTH(DEPTH)) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drainState_q <= D_IDLE;
      loadState_q  <= L_IDLE;
      rdata_q      <= '0;
    end else begin
      drainState_q <= drainState_d;
      loadState_q  <= loadState_d;
      rdata_q      <= rdata_d;
    end
  end

  // A blocked display write stays at the head and re-probes the ready flag every cycle.
  always_comb begin
    drainState_d = drainState_q;
    pop          = 1'b0;
    drainWe      = 1'b0;
    drainAddr    = 8'h00;
    drainDout    = 32'h0;
    case (drainState_q)
      D_IDLE: begin
        if (!empty) begin
`ifdef IO_SEG_PACE_EN
          if (head.addr == IO_SEG) begin
            drainAddr = IO_SEG_RDY;
            if (bus.io_din[0]) drainState_d = D_SEGWR;
          end else begin
            drainWe   = 1'b1;
            drainAddr = head.addr;
            drainDout = head.data;
            pop       = 1'b1;
          end
`else
          drainWe   = 1'b1;
          drainAddr = head.addr;
          drainDout = head.data;
          pop       = 1'b1;
`endif
        end
      end
`ifdef IO_SEG_PACE_EN
      D_SEGWR: begin
        drainWe      = 1'b1;
        drainAddr    = IO_SEG;
        drainDout    = head.data;
        pop          = 1'b1;
        drainState_d = D_IDLE;
      end
`endif
      default: drainState_d = D_IDLE;
    endcase
  end

  // Loads wait for an empty FIFO so they never overtake posted stores or share the bus.
  always_comb begin
    loadState_d = loadState_q;
    loadRd      = 1'b0;
    loadAddr    = 8'h00;
    loadStall   = 1'b0;
    rdata_d     = rdata_q;
    case (loadState_q)
      L_IDLE: begin
        if (ioLoad) begin
          loadStall = 1'b1;
          if (empty && drainState_q == D_IDLE) begin
            loadRd      = 1'b1;
            loadAddr    = bus.cpu_addr[7:0];
            rdata_d     = bus.io_din;
            loadState_d = L_RESP;
          end
        end
      end
      default: loadState_d = L_IDLE;
    endcase
  end

  assign bus.dm_we     = bus.cpu_we & ~ioHit;
  assign bus.cpu_stall = (ioStore & full) | loadStall;
  assign bus.cpu_rdata = (loadState_q == L_RESP) ? rdata_q : bus.dm_rdata;
  assign bus.io_addr   = empty ? loadAddr : drainAddr;
  assign bus.io_dout   = drainDout;
  assign bus.io_we     = drainWe;
  assign bus.io_rd     = loadRd;

endmodule

// File: doc/io_bridge.md
# io_bridge

CPU-side memory-mapped I/O bridge placed between the CPU data-memory port and the PDU I/O bus (`io_addr`/`io_dout`/`io_we`/`io_rd`/`io_din`). It decodes the I/O window and passes ordinary accesses to data memory. I/O stores go into a small posted-write FIFO that drains onto the bus. Each I/O load produces exactly one `io_rd` pulse, so read-to-clear PDU registers (0x14 switch data, 0x20 button data) stay correct. Optionally, writes to the display port are paced by the PDU's display-ready flag.

## Interface
- `DEPTH`, 4: write-FIFO entries; power of two, ≥2.
- `clk`  in  1  CPU clock (same as PDU `clk_cpu`).
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  32  data address; held stable while `cpu_stall`=1.
- `cpu_wdata`  in  32  store data.
- `cpu_we` / `cpu_re`  in  1  store / load request; never both high.
- `cpu_rdata`  out  32  load data to CPU.
- `cpu_stall`  out  1  freeze the CPU this cycle.
- `dm_we`  out  1  data-memory write enable = `cpu_we` & ~io_hit.
- `dm_rdata`  in  32  data-memory read data.
- `io_addr`  out  8  PDU I/O address.
- `io_dout`  out  32  PDU write data.
- `io_we` / `io_rd`  out  1  PDU write / read strobes.
- `io_din`  in  32  PDU read data (combinational in `io_addr`).

## Operation
- `io_hit` = `cpu_addr[31:8]`==24'hFFFFFF. Bus offset = `cpu_addr[7:0]`.
- **I/O store:** pushes {offset, wdata} when the FIFO is not full; `cpu_stall`=0. When full, `cpu_stall`=1 and nothing is pushed. A pop in the same cycle does not relieve full.
- **Drain FSM** has two states, D_IDLE and D_SEGWR.
  - D_IDLE, empty: bus idle.
  - D_IDLE, head offset ≠ 0x0C: `io_we`=1, `io_addr`/`io_dout` = head, pop; stay in D_IDLE.
  - D_IDLE, head = 0x0C (pacing on): probe by driving `io_addr`=0x08 with `io_we`=`io_rd`=0. If `io_din[0]`=1, go to D_SEGWR; otherwise stay and re-probe next cycle.
  - D_SEGWR: `io_we`=1, addr 0x0C, pop; go to D_IDLE.
- **I/O load FSM** has two states, L_IDLE and L_RESP.
  - Condition: I/O load, FIFO empty, drain FSM in D_IDLE.
  - When met in L_IDLE: `io_rd`=1, `io_addr`=offset, `io_din` captured into `rdata_r`, `cpu_stall`=1; go to L_RESP.
  - When not met: `cpu_stall`=1, no bus activity.
  - L_RESP: `cpu_stall`=0, `cpu_rdata`=`rdata_r`; unconditionally return to L_IDLE.
  - Loads never bypass queued stores.
- **Memory load:** `cpu_rdata`=`dm_rdata`, no stall.
- **Bus ownership:** the load path drives the bus only when the FIFO is empty, so the two paths never conflict. `io_we` and `io_rd` are never high together.
- **Known hazard:** an I/O load issued behind a blocked 0x0C write stalls until the user releases the display (PDU sets ready).

## Timing
- Reset values: FIFO empty, D_IDLE, L_IDLE, `rdata_r`=0. All outputs are 0 except `dm_we` and `cpu_rdata`, which follow their equations.
- Reset mid-operation discards queued writes and any pending load.
- Store-to-bus latency is 1 cycle when the FIFO is empty (push at edge N, `io_we` high in cycle N+1).
- Paced 0x0C write: earliest 2 cycles after reaching the head (probe cycle, then write cycle).
- I/O load with empty FIFO: 2 cycles, exactly 1 `io_rd` pulse.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle leave the count unchanged.

## Configuration
- `IO_SEG_PACE_EN` defined: 0x0C writes use the probe/D_SEGWR path described above.
- Undefined: D_SEGWR is removed, 0x0C drains like any other offset, and no probe cycles occur.

## Structure
- Package `io_bridge_pkg`:
  - `IO_BASE`=24'hFFFFFF.
  - Offsets `IO_SEG`=8'h0C, `IO_SEG_RDY`=8'h08, `IO_SWX`=8'h14, `IO_BTN`=8'h20.
  - FIFO entry struct {addr[7:0], data[31:0]}.
  - Drain and load state enums.
- Sub-module `io_wbuf`: parameterised synchronous FIFO with push/pop/full/empty/head.

## Test plan
- **Reset:** assert `rst` mid-drain with 3 entries queued → next cycle `io_we`=0, `io_rd`=0, `cpu_stall`=0, queue empty, no further writes.
- **Single write:** store 0xFFFFFF40 ← 0xDEADBEEF → no stall; next cycle `io_we`=1, `io_addr`=0x40, `io_dout`=0xDEADBEEF, for exactly 1 cycle.
- **Pacing:** PDU model with seg_rdy=0; store 0x0C ← 0x1, then stores 0x40 ← 2, 3, 4.
  - Expected: a 5th store stalls.
  - Raise seg_rdy → the 0x0C write appears after the probe, then 2, 3, 4 on consecutive cycles; the 5th store is accepted.
- **Read-to-clear:** load 0xFFFFFF14 with model data 0xCAFE0001 → exactly one `io_rd` with `io_addr`=0x14; `cpu_rdata`=0xCAFE0001 in cycle 2; `cpu_stall` high for 1 cycle.
- **Ordering:** store 0x40 ← 7 then immediately load 0x40 → the load stalls until the write drains; `io_rd` occurs after `io_we`; the load returns 7.
- **Memory path:** store 0x00000010 ← 5 → `dm_we`=1, no I/O strobe; load 0x10 → `cpu_rdata`=`dm_rdata`, no stall.
